// File: rtl/lat_memory_pkg.sv
// Shared types and address helpers for the latency-configurable memory responder.
package lat_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int offset_bits_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [31:0] word_index(input logic [31:0] addr, input int offset_bits);
    return addr >> offset_bits;
  endfunction

endpackage

// File: rtl/lat_memory_array.sv
// Single-port word storage with per-byte write enables and a registered read port.
module lat_memory_array
  import lat_memory_pkg::*;
#(
  parameter int  DATA_WIDTH  = 32,
  parameter int  DEPTH_WORDS = 1024,
  localparam int BYTES       = bytes_of(DATA_WIDTH),
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic                  rd_zero,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BYTES-1:0]      wmask,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

  // Byte-masked write; a reset coinciding with the commit edge suppresses it.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wmask[b]) begin
          mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register holds its value between reads; out-of-range reads return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[idx];
    end
  end

endmodule

// File: rtl/lat_memory.sv
// Memory responder with configurable latency: request latch, countdown FSM and error flagging.
module lat_memory
  import lat_memory_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    resp,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    error
);

  localparam int         BYTES       = bytes_of(DATA_WIDTH);
  localparam int         OFFSET_BITS = offset_bits_of(DATA_WIDTH);
  localparam int         IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [7:0] CNT_LOAD    = 8'(LATENCY - 1);

  state_e                state_r, state_next_s;
  logic [7:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] lat_addr_r;
  logic [DATA_WIDTH-1:0] lat_wdata_r;
  logic [BYTES-1:0]      lat_wmask_r;
  logic                  lat_read_r, lat_write_r;
  logic                  err_r, err_next_s;
  logic                  resp_r, error_r;

  logic                  idle_s, req_s, mismatch_s, enter_resp_s, in_range_s;
  logic                  cur_read_s, cur_write_s, we_s, re_s;
  logic [ADDR_WIDTH-1:0] cur_addr_s;
  logic [DATA_WIDTH-1:0] cur_wdata_s;
  logic [BYTES-1:0]      cur_wmask_s;
  logic [31:0]           addr_ext_s, idx_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign req_s      = read | write;
  assign mismatch_s = (lat_read_r & ~read) | (lat_write_r & ~write) | (address != lat_addr_r);

  // With LATENCY=1 the commit happens on the sampling edge, so the live inputs are used then.
  always_comb begin
    if (idle_s) begin
      cur_read_s  = read;
      cur_write_s = write;
      cur_addr_s  = address;
      cur_wdata_s = wdata;
      cur_wmask_s = wmask;
    end else begin
      cur_read_s  = lat_read_r;
      cur_write_s = lat_write_r;
      cur_addr_s  = lat_addr_r;
      cur_wdata_s = lat_wdata_r;
      cur_wmask_s = lat_wmask_r;
    end
  end

  assign addr_ext_s = 32'(cur_addr_s);
  assign idx_s      = word_index(addr_ext_s, OFFSET_BITS);
  assign in_range_s = (idx_s < 32'(DEPTH_WORDS));

  // Next state and accumulated error for the transaction in flight.
  always_comb begin
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_next_s = (LATENCY == 1) ? ST_RESP : ST_WAIT;
          err_next_s   = ~in_range_s | (read & write);
        end else begin
          state_next_s = ST_IDLE;
          err_next_s   = 1'b0;
        end
      end
      ST_WAIT: begin
        state_next_s = (cnt_r == 8'd1) ? ST_RESP : ST_WAIT;
        err_next_s   = err_r | mismatch_s;
      end
      ST_RESP: begin
        state_next_s = ST_IDLE;
        err_next_s   = 1'b0;
      end
      default: begin
        state_next_s = ST_IDLE;
        err_next_s   = 1'b0;
      end
    endcase
  end

  assign enter_resp_s = (state_next_s == ST_RESP) && (state_r != ST_RESP);
  assign we_s         = enter_resp_s & cur_write_s & ~cur_read_s & in_range_s;
  assign re_s         = enter_resp_s & cur_read_s;

  // FSM, countdown, request latch and registered response flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 8'd0;
      err_r       <= 1'b0;
      resp_r      <= 1'b0;
      error_r     <= 1'b0;
      lat_read_r  <= 1'b0;
      lat_write_r <= 1'b0;
      lat_addr_r  <= {ADDR_WIDTH{1'b0}};
      lat_wdata_r <= {DATA_WIDTH{1'b0}};
      lat_wmask_r <= {BYTES{1'b0}};
    end else begin
      state_r <= state_next_s;
      err_r   <= err_next_s;
      resp_r  <= enter_resp_s;
      error_r <= enter_resp_s & err_next_s;
      if (idle_s && req_s) begin
        cnt_r       <= CNT_LOAD;
        lat_read_r  <= read;
        lat_write_r <= write;
        lat_addr_r  <= address;
        lat_wdata_r <= wdata;
        lat_wmask_r <= wmask;
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

  lat_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (we_s),
    .re     (re_s),
    .rd_zero(~in_range_s),
    .idx    (idx_s[IDX_W-1:0]),
    .wdata  (cur_wdata_s),
    .wmask  (cur_wmask_s),
    .rdata  (rdata)
  );

  assign resp  = resp_r;
  assign error = error_r;

endmodule

// File: tb/tb_lat_memory.sv
// Randomised and directed bench for lat_memory against a word-array reference model.
module tb_lat_memory;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst, read, write;
  logic [3:0]  wmask;
  logic [15:0] address;
  logic [31:0] wdata, rdata;
  logic        resp, error;

  logic        rst_h, rd_h, wr_h;
  logic [3:0]  wm_h;
  logic [15:0] ad_h;
  logic [31:0] wd_h, rdata1, rdata255;
  logic        resp1, err1, resp255, err255;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [0:1023];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  lat_memory #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .wmask(wmask),
    .address(address), .wdata(wdata), .resp(resp), .rdata(rdata), .error(error)
  );

  lat_memory #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst_h), .read(rd_h), .write(wr_h), .wmask(wm_h),
    .address(ad_h), .wdata(wd_h), .resp(resp1), .rdata(rdata1), .error(err1)
  );

  lat_memory #(.LATENCY(255)) dut_l255 (
    .clk(clk), .rst(rst_h), .read(rd_h), .write(wr_h), .wmask(wm_h),
    .address(ad_h), .wdata(wd_h), .resp(resp255), .rdata(rdata255), .error(err255)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: clean, 1: request dropped in WAIT, 2: address changed in WAIT
  task automatic txn(input logic r, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input logic [3:0] m, input int mode);
    int   k;
    int   idx;
    logic inr;
    logic exp_err;
    idx     = int'(a >> 2);
    inr     = (idx < 1024);
    exp_err = !inr || (r && w) || (mode != 0);
    @(negedge clk);
    read = r; write = w; address = a; wdata = d; wmask = m;
    k = 0;
    for (int n = 1; n <= LAT + 2 && k == 0; n++) begin
      @(negedge clk);
      if (n == 1 && mode == 1) begin read = 1'b0; write = 1'b0; end
      if (n == 1 && mode == 2) address = a ^ 16'h0004;
      if (resp) k = n;
    end
    read = 1'b0; write = 1'b0;
    check("latency", 32'(k), 32'(LAT));
    check("error", 32'(error), 32'(exp_err));
    if (r) exp_rdata = inr ? model[idx] : 32'h0;
    check("rdata", rdata, exp_rdata);
    if (w && !r && inr) begin
      for (int b = 0; b < 4; b++) begin
        if (m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(negedge clk);
    check("resp_pulse", 32'(resp), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          last1, last255, g1, g255, n255, k;
    int          wi, op, mode;
    logic        r, w;
    logic [31:0] v;
    rst = 1'b1; read = 1'b0; write = 1'b0; wmask = 4'h0; address = 16'h0; wdata = 32'h0;
    rst_h = 1'b1; rd_h = 1'b0; wr_h = 1'b0; wm_h = 4'hF; ad_h = 16'h0; wd_h = 32'h5A5A_A5A5;
    exp_rdata = 32'h0;
    for (int i = 0; i < 1024; i++) model[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_resp", 32'(resp), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v = (i == 12) ? 32'h0 : ($urandom | 32'h1);
      txn(1'b0, 1'b1, 16'(i * 4), v, 4'hF, 0);
    end

    txn(1'b0, 1'b1, 16'h0010, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0, 0);
    check("deadbeef", rdata, 32'hDEAD_BEEF);

    txn(1'b0, 1'b1, 16'h0020, 32'h1122_3344, 4'hF, 0);
    txn(1'b0, 1'b1, 16'h0020, 32'hAABB_CCDD, 4'b0101, 0);
    txn(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0, 0);
    check("bytemask", rdata, 32'h11BB_33DD);

    txn(1'b0, 1'b1, 16'h1000, 32'h1234_5678, 4'hF, 0);
    txn(1'b1, 1'b0, 16'h1000, 32'h0, 4'h0, 0);
    txn(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0, 0);

    txn(1'b1, 1'b1, 16'h0014, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1'b1, 1'b0, 16'h0014, 32'h0, 4'h0, 0);
    txn(1'b1, 1'b0, 16'h000C, 32'h0, 4'h0, 1);
    txn(1'b1, 1'b0, 16'h0008, 32'h0, 4'h0, 2);

    // reset while the write is waiting: nothing commits
    @(negedge clk);
    write = 1'b1; address = 16'h0030; wdata = 32'hCAFE_F00D; wmask = 4'hF;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstwait_resp", 32'(resp), 32'h0);
    check("rstwait_error", 32'(error), 32'h0);
    write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'h0;
    txn(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0, 0);
    check("rstwait_data", rdata, 32'h0);

    // reset during an erroring response: resp, error and rdata clear at once
    txn(1'b1, 1'b0, 16'h0004, 32'h0, 4'h0, 0);
    @(negedge clk);
    write = 1'b1; address = 16'h1000; wdata = 32'h1; wmask = 4'hF;
    repeat (LAT) @(negedge clk);
    check("rstresp_pre_resp", 32'(resp), 32'h1);
    check("rstresp_pre_err", 32'(error), 32'h1);
    rst = 1'b1;
    #1;
    check("rstresp_resp", 32'(resp), 32'h0);
    check("rstresp_error", 32'(error), 32'h0);
    check("rstresp_rdata", rdata, 32'h0);
    write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rdata = 32'h0;

    for (int t = 0; t < 200; t++) begin
      wi = $urandom_range(0, 19);
      if (wi >= 16) wi = 1024 + wi - 16;
      op = $urandom_range(0, 19);
      r = (op < 9) || (op >= 18);
      w = (op >= 9);
      mode = ($urandom_range(0, 19) == 0) ? 1 : (($urandom_range(0, 19) == 0) ? 2 : 0);
      txn(r, w, 16'(wi * 4 + $urandom_range(0, 3)), $urandom, 4'($urandom), mode);
    end

    // latency extremes: one write to word 0, then reads held high continuously
    @(negedge clk);
    rst_h = 1'b0;
    @(negedge clk);
    wr_h = 1'b1;
    k = 0;
    for (int n = 0; n < 300 && k == 0; n++) begin
      @(negedge clk);
      if (resp255) k = 1;
    end
    wr_h = 1'b0;
    check("l255_write_done", 32'(k), 32'h1);
    repeat (2) @(negedge clk);
    rd_h = 1'b1;
    last1 = -1; last255 = -1; g1 = 0; g255 = 0; n255 = 0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      @(negedge clk);
      if (resp1) begin
        if (last1 >= 0 && g1 < 5) begin
          check("l1_gap", 32'(cyc - last1), 32'd2);
          check("l1_rdata", rdata1, wd_h);
          check("l1_error", 32'(err1), 32'h0);
          g1++;
        end
        last1 = cyc;
      end
      if (resp255) begin
        n255++;
        check("l255_rdata", rdata255, wd_h);
        check("l255_error", 32'(err255), 32'h0);
        if (last255 >= 0 && g255 < 5) begin
          check("l255_gap", 32'(cyc - last255), 32'd256);
          g255++;
        end
        last255 = cyc;
      end
    end
    rd_h = 1'b0;
    check("l255_pulses", 32'(n255 >= 3), 32'h1);
    check("l1_gaps_seen", 32'(g1), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
